noc_output_arbiter: RTL and testbench

- Round-robin arbiter and credit-flow controller for one router output port in the 4x4 mesh.
- Up to NUM_REQ input ports compete for the port: N, E, S, W and Local.
- Forwards one 16-bit flit per cycle: upper nibble is the source node, next nibble is the destination node, low byte is the payload.
- Tracks downstream buffer credits so the next router is never overrun.

---
 rtl/noc_output_arbiter.sv | 123 ++++++++++++
 tb/tb_noc_output_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_arbiter.sv
// Round-robin output-port arbiter with downstream credit tracking for one mesh router port.
// Forwards at most one flit per cycle, registered, and refuses grants when no credit is left.
module noc_output_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int DATA_W  = 16,
  parameter int CREDITS = 4,
  parameter int CRED_W  = 3,
  parameter int IDX_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [IDX_W-1:0]          out_src,
  input  logic                      credit_in,
  output logic [CRED_W-1:0]         credit_cnt,
  output logic                      err_overflow,
  output logic [IDX_W-1:0]          dbg_ptr
);

  // Handshake: a requester holds req_valid/req_data until it sees req_ready high;
  // the flit is consumed at the rising edge of any cycle where valid && ready.

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CRED_W-1:0] credit_cnt_q, credit_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_src_q, out_src_d;
  logic              err_overflow_q, err_overflow_d;

  logic              grant;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W:0]    cand;
  logic              has_credit;
  logic              cnt_full;

  assign has_credit = (credit_cnt_q != '0);
  assign cnt_full   = (credit_cnt_q == CRED_W'(CREDITS));

  // Search starts at ptr and wraps; only the registered credit count can enable a grant.
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    cand   = '0;
    if (!rst && has_credit) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        cand = {1'b0, ptr_q} + (IDX_W+1)'(off);
        if (cand >= (IDX_W+1)'(NUM_REQ)) begin
          cand = cand - (IDX_W+1)'(NUM_REQ);
        end
        if (!grant && req_valid[cand[IDX_W-1:0]]) begin
          grant  = 1'b1;
          winner = cand[IDX_W-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    ptr_d          = ptr_q;
    out_valid_d    = 1'b0;
    out_data_d     = out_data_q;
    out_src_d      = out_src_q;
    credit_cnt_d   = credit_cnt_q;
    err_overflow_d = err_overflow_q;

    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = req_data[int'(winner)*DATA_W +: DATA_W];
      out_src_d   = winner;
      ptr_d       = (winner == IDX_W'(NUM_REQ-1)) ? '0 : winner + IDX_W'(1);
    end

    // A returned credit against a full counter is only an error if no grant consumes one.
    case ({grant, credit_in})
      2'b10: credit_cnt_d = credit_cnt_q - CRED_W'(1);
      2'b01: begin
        if (cnt_full) begin
          err_overflow_d = 1'b1;
        end else begin
          credit_cnt_d = credit_cnt_q + CRED_W'(1);
        end
      end
      default: credit_cnt_d = credit_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q          <= '0;
      credit_cnt_q   <= CRED_W'(CREDITS);
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_src_q      <= '0;
      err_overflow_q <= 1'b0;
    end else begin
      ptr_q          <= ptr_d;
      credit_cnt_q   <= credit_cnt_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_src_q      <= out_src_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_src      = out_src_q;
  assign credit_cnt   = credit_cnt_q;
  assign err_overflow = err_overflow_q;
  assign dbg_ptr      = ptr_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter: reset, round-robin, credit exhaustion,
// credit/grant collision, overflow flag, mid-traffic reset and pointer wrap.
module tb_noc_output_arbiter;

  localparam int NUM_REQ = 5;
  localparam int DATA_W  = 16;
  localparam int CRED_W  = 3;
  localparam int IDX_W   = 3;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [IDX_W-1:0]          out_src;
  logic                      credit_in;
  logic [CRED_W-1:0]         credit_cnt;
  logic                      err_overflow;
  logic [IDX_W-1:0]          dbg_ptr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] flits [NUM_REQ];

  noc_output_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_src      (out_src),
    .credit_in    (credit_in),
    .credit_cnt   (credit_cnt),
    .err_overflow (err_overflow),
    .dbg_ptr      (dbg_ptr)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle 1 ns so registered outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic load_flits();
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = flits[i];
  endtask

  initial begin
    flits[0] = 16'h0f55;
    flits[1] = 16'h1555;
    flits[2] = 16'h2955;
    flits[3] = 16'h3755;
    flits[4] = 16'h4355;
    rst = 1'b1; req_valid = '0; req_data = '0; credit_in = 1'b0;
    #2;

    // 1) Reset then single request on port 0
    do_reset(2);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_credit", 32'(credit_cnt), 32'd4);
    chk("rst_err", 32'(err_overflow), 32'd0);
    chk("rst_ptr", 32'(dbg_ptr), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    load_flits();
    req_valid = 5'b00001;
    #1;
    chk("single_ready", 32'(req_ready), 32'b00001);
    tick();
    req_valid = '0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'h0f55);
    chk("single_src", 32'(out_src), 32'd0);
    chk("single_credit", 32'(credit_cnt), 32'd3);
    tick();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_hold_data", 32'(out_data), 32'h0f55);

    // 2) Round robin over all five ports, credit returned from the second grant on
    do_reset(1);
    req_valid = 5'b11111;
    for (int k = 0; k < 10; k++) begin
      credit_in = (k >= 1);
      #1;
      chk("rr_ready", 32'(req_ready), 32'(1 << (k % 5)));
      tick();
      chk("rr_src", 32'(out_src), 32'(k % 5));
      chk("rr_data", 32'(out_data), 32'(flits[k % 5]));
      chk("rr_credit", 32'(credit_cnt), 32'd3);
    end
    credit_in = 1'b0;
    req_valid = '0;

    // 3) Credit exhaustion with ports 1 and 3
    do_reset(1);
    req_valid = 5'b01010;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("exh_src", 32'(out_src), (k % 2 == 0) ? 32'd1 : 32'd3);
      chk("exh_credit", 32'(credit_cnt), 32'(3 - k));
    end
    #1;
    chk("exh_ready_zero", 32'(req_ready), 32'd0);
    tick();
    chk("exh_no_valid", 32'(out_valid), 32'd0);
    chk("exh_credit_zero", 32'(credit_cnt), 32'd0);
    credit_in = 1'b1;
    #1;
    chk("exh_same_cycle_ready", 32'(req_ready), 32'd0);
    tick();
    credit_in = 1'b0;
    chk("exh_credit_back", 32'(credit_cnt), 32'd1);
    chk("exh_no_valid2", 32'(out_valid), 32'd0);
    #1;
    chk("exh_next_ready", 32'(req_ready), 32'b00010);
    tick();
    req_valid = '0;
    chk("exh_grant_src", 32'(out_src), 32'd1);
    chk("exh_grant_credit", 32'(credit_cnt), 32'd0);

    // 4) Grant plus credit at count 2, then overflow at full count
    credit_in = 1'b1;
    tick(); tick();
    chk("coll_pre_credit", 32'(credit_cnt), 32'd2);
    req_valid = 5'b00001;
    tick();
    req_valid = '0;
    chk("coll_credit", 32'(credit_cnt), 32'd2);
    chk("coll_src", 32'(out_src), 32'd0);
    chk("coll_err", 32'(err_overflow), 32'd0);
    tick(); tick();
    chk("ovf_pre_credit", 32'(credit_cnt), 32'd4);
    chk("ovf_pre_err", 32'(err_overflow), 32'd0);
    tick();
    credit_in = 1'b0;
    chk("ovf_credit", 32'(credit_cnt), 32'd4);
    chk("ovf_err", 32'(err_overflow), 32'd1);
    tick(); tick();
    chk("ovf_sticky", 32'(err_overflow), 32'd1);

    // 5) Reset while port 2 requests with one credit left
    req_valid = 5'b00100;
    repeat (3) tick();
    chk("mid_pre_credit", 32'(credit_cnt), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_ready_in_rst", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    req_valid = '0;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_credit", 32'(credit_cnt), 32'd4);
    chk("mid_ptr", 32'(dbg_ptr), 32'd0);
    chk("mid_err", 32'(err_overflow), 32'd0);

    // 6) Pointer wrap after a grant to port 4
    req_valid = 5'b10000;
    tick();
    chk("wrap_src4", 32'(out_src), 32'd4);
    chk("wrap_ptr", 32'(dbg_ptr), 32'd0);
    req_valid = 5'b01001;
    #1;
    chk("wrap_ready0", 32'(req_ready), 32'b00001);
    tick();
    chk("wrap_src0", 32'(out_src), 32'd0);
    chk("wrap_data0", 32'(out_data), 32'h0f55);
    #1;
    chk("wrap_ready3", 32'(req_ready), 32'b01000);
    tick();
    req_valid = '0;
    chk("wrap_src3", 32'(out_src), 32'd3);
    chk("wrap_data3", 32'(out_data), 32'h3755);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
